fetch_ctrl: RTL and testbench

Sequencing controller for the program counter. Owns the PC's `reset`, `absjump_en` and `target` inputs and decides when instruction fetch is valid. Runs a start/run/flush/done state machine with a one-bubble registered branch, halt, and PC wrap detection. Sits between the instruction decoder and the program counter, and exposes busy/done status plus a run-cycle counter to the top level.

---
 rtl/fetch_pkg.sv | 5 +
 rtl/fetch_ctrl_if.sv | 29 ++
 rtl/sat_counter.sv | 20 ++
 rtl/fetch_ctrl.sv | 75 +++++++
 tb/tb_fetch_ctrl.sv | 126 ++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and target width for the fetch controller
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} fetch_state_t;
    localparam int PC_TGT_W = 8;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: decoder/PC-facing signal bundle of the fetch controller
interface fetch_ctrl_if #(
    parameter int D  = 10,
    parameter int CW = 16
);
    import fetch_pkg::*;
    logic                start;
    logic [D-1:0]        prog_ctr;
    logic                branch_req;
    logic                branch_taken;
    logic [PC_TGT_W-1:0] branch_target;
    logic                halt_req;
    logic                pc_reset;
    logic                pc_jump_en;
    logic [PC_TGT_W-1:0] pc_target;
    logic                fetch_valid;
    logic                busy;
    logic                done;
    logic                wrap_err;
    logic [CW-1:0]       cycle_count;
    modport master (
        output start, prog_ctr, branch_req, branch_taken, branch_target, halt_req,
        input  pc_reset, pc_jump_en, pc_target, fetch_valid, busy, done, wrap_err, cycle_count
    );
    modport slave (
        input  start, prog_ctr, branch_req, branch_taken, branch_target, halt_req,
        output pc_reset, pc_jump_en, pc_target, fetch_valid, busy, done, wrap_err, cycle_count
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q, cnt_d;
    // clear wins over increment; increment stops once every bit is set
    always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    // count register
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
    assign q = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: start/run/flush/done sequencer driving the PC reset, jump and target
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int D  = 10,
    parameter int CW = 16
) (
    input logic         clk,
    input logic         reset_n,
    fetch_ctrl_if.slave bus
);
    if (D != 10) begin : g_bad_d
        $error("fetch_ctrl: D must be 10 so the 8-bit target fills prog_ctr[D-1:2]");
    end
    fetch_state_t        state_q, state_d;
    logic                jump_q, jump_d;
    logic [PC_TGT_W-1:0] target_q, target_d;
    logic                wrap_q, wrap_d;
    logic                cnt_clr;
    // next state; in RUN halt beats a taken branch, which beats PC wrap
    always_comb begin
        state_d  = state_q;
        jump_d   = 1'b0;
        target_d = target_q;
        wrap_d   = wrap_q;
        cnt_clr  = 1'b0;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d = RUN;
                cnt_clr = 1'b1;
                wrap_d  = 1'b0;
            end
            RUN: if (bus.halt_req) begin
                state_d = DONE;
            end else if (bus.branch_req && bus.branch_taken) begin
                state_d  = FLUSH;
                jump_d   = 1'b1;
                target_d = bus.branch_target;
            end else if (&bus.prog_ctr) begin
                state_d = DONE;
                wrap_d  = 1'b1;
            end
            FLUSH: state_d = RUN;
            default: state_d = IDLE;
        endcase
    end
    // state and registered outputs; reset drops any pending jump
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            jump_q   <= 1'b0;
            target_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            jump_q   <= jump_d;
            target_q <= target_d;
            wrap_q   <= wrap_d;
        end
    end
    assign bus.pc_reset    = !reset_n || state_q == IDLE || state_q == DONE;
    assign bus.fetch_valid = state_q == RUN;
    assign bus.busy        = state_q == RUN || state_q == FLUSH;
    assign bus.done        = state_q == DONE;
    assign bus.pc_jump_en  = jump_q;
    assign bus.pc_target   = target_q;
    assign bus.wrap_err    = wrap_q;
    sat_counter #(.W(CW)) u_cycles (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (bus.busy),
        .q       (bus.cycle_count)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector bench for fetch_ctrl with a behavioural PC in the loop
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    fetch_ctrl_if #(.D(10), .CW(16)) bus ();
    fetch_ctrl_if #(.D(10), .CW(4))  bus4 ();
    fetch_ctrl #(.D(10), .CW(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    fetch_ctrl #(.D(10), .CW(4))  dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
    // program counter: reset to 0, absolute jump to {target,00}, else increment
    always_ff @(posedge clk) begin
        bus.prog_ctr  <= bus.pc_reset ? '0 : bus.pc_jump_en ? {bus.pc_target, 2'b00} : bus.prog_ctr + 1'b1;
        bus4.prog_ctr <= bus4.pc_reset ? '0 : bus4.pc_jump_en ? {bus4.pc_target, 2'b00} : bus4.prog_ctr + 1'b1;
    end
    typedef struct packed {
        logic        rn, st, br, tk;
        logic [7:0]  tg;
        logic        hl;
        logic [9:0]  pc;
        logic        fv, bz, dn, je, pr;
        logic [7:0]  ptg;
        logic [15:0] cc;
    } vec_t;
    vec_t vecs [20];
    function automatic vec_t mk(int rn, int st, int br, int tk, int tg, int hl,
                                int pc, int fv, int bz, int dn, int je, int pr, int ptg, int cc);
        vec_t v;
        v.rn = rn[0]; v.st = st[0]; v.br = br[0]; v.tk = tk[0]; v.tg = tg[7:0]; v.hl = hl[0];
        v.pc = pc[9:0]; v.fv = fv[0]; v.bz = bz[0]; v.dn = dn[0]; v.je = je[0]; v.pr = pr[0];
        v.ptg = ptg[7:0]; v.cc = cc[15:0];
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic st, input logic br, input logic tk, input logic [7:0] tg, input logic hl);
        bus.start = st; bus.branch_req = br; bus.branch_taken = tk; bus.branch_target = tg; bus.halt_req = hl;
    endtask
    initial begin
        vecs[0]  = mk(1,1,0,0,'h00,0,   0,0,0,0,0,1,'h00,0);
        vecs[1]  = mk(1,0,0,0,'h00,0,   0,1,1,0,0,0,'h00,0);
        vecs[2]  = mk(1,0,0,0,'h00,0,   1,1,1,0,0,0,'h00,1);
        vecs[3]  = mk(1,0,0,0,'h00,0,   2,1,1,0,0,0,'h00,2);
        vecs[4]  = mk(1,0,1,0,'h07,0,   3,1,1,0,0,0,'h00,3);
        vecs[5]  = mk(1,0,0,0,'h00,0,   4,1,1,0,0,0,'h00,4);
        vecs[6]  = mk(1,0,1,1,'h02,0,   5,1,1,0,0,0,'h00,5);
        vecs[7]  = mk(1,0,1,1,'h33,1,   6,0,1,0,1,0,'h02,6);
        vecs[8]  = mk(1,0,1,1,'h11,1,   8,1,1,0,0,0,'h02,7);
        vecs[9]  = mk(1,0,0,0,'h00,0,   9,0,0,1,0,1,'h02,8);
        vecs[10] = mk(1,1,0,0,'h00,0,   0,0,0,1,0,1,'h02,8);
        vecs[11] = mk(1,0,0,0,'h00,0,   0,1,1,0,0,0,'h02,0);
        vecs[12] = mk(1,1,0,0,'h00,0,   1,1,1,0,0,0,'h02,1);
        vecs[13] = mk(1,0,0,0,'h00,0,   2,1,1,0,0,0,'h02,2);
        vecs[14] = mk(1,0,1,1,'h05,0,   3,1,1,0,0,0,'h02,3);
        vecs[15] = mk(1,0,0,0,'h00,0,   4,0,1,0,1,0,'h05,4);
        vecs[16] = mk(1,0,0,0,'h00,0,  20,1,1,0,0,0,'h05,5);
        vecs[17] = mk(1,0,1,1,'h40,0,  21,1,1,0,0,0,'h05,6);
        vecs[18] = mk(0,0,0,0,'h00,0,  22,0,1,0,1,1,'h40,7);
        vecs[19] = mk(1,0,0,0,'h00,0,   0,0,0,0,0,1,'h00,0);
        drive(0, 0, 0, 8'h00, 0);
        bus4.start = 0; bus4.branch_req = 0; bus4.branch_taken = 0; bus4.branch_target = '0; bus4.halt_req = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_reset", 32'(bus.pc_reset), 1);
        chk("rst_jump_en", 32'(bus.pc_jump_en), 0);
        chk("rst_target", 32'(bus.pc_target), 0);
        chk("rst_status", {28'd0, bus.fetch_valid, bus.busy, bus.done, bus.wrap_err}, 0);
        chk("rst_cycle_count", 32'(bus.cycle_count), 0);
        chk("rst_prog_ctr", 32'(bus.prog_ctr), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            reset_n = vecs[i].rn;
            drive(vecs[i].st, vecs[i].br, vecs[i].tk, vecs[i].tg, vecs[i].hl);
            #1;
            chk($sformatf("v%0d_prog_ctr", i), 32'(bus.prog_ctr), 32'(vecs[i].pc));
            chk($sformatf("v%0d_fetch_valid", i), 32'(bus.fetch_valid), 32'(vecs[i].fv));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].bz));
            chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].dn));
            chk($sformatf("v%0d_jump_en", i), 32'(bus.pc_jump_en), 32'(vecs[i].je));
            chk($sformatf("v%0d_pc_reset", i), 32'(bus.pc_reset), 32'(vecs[i].pr));
            chk($sformatf("v%0d_pc_target", i), 32'(bus.pc_target), 32'(vecs[i].ptg));
            chk($sformatf("v%0d_cycle_count", i), 32'(bus.cycle_count), 32'(vecs[i].cc));
            chk($sformatf("v%0d_wrap_err", i), 32'(bus.wrap_err), 0);
        end
        // wrap: jump to 8'hFF, run through 1020..1023, end in DONE with wrap_err
        @(negedge clk); drive(1, 0, 0, 8'h00, 0);
        @(negedge clk); drive(0, 1, 1, 8'hFF, 0);
        @(negedge clk); drive(0, 0, 0, 8'h00, 0);
        @(negedge clk); #1;
        chk("wrap_jump_pc", 32'(bus.prog_ctr), 1020);
        for (int n = 0; n < 10 && bus.prog_ctr != 10'd1023; n++) @(negedge clk);
        #1;
        chk("wrap_reach_1023", 32'(bus.prog_ctr), 1023);
        chk("wrap_last_valid", 32'(bus.fetch_valid), 1);
        chk("wrap_not_done_yet", 32'(bus.done), 0);
        @(negedge clk); #1;
        chk("wrap_done", 32'(bus.done), 1);
        chk("wrap_err_set", 32'(bus.wrap_err), 1);
        chk("wrap_count", 32'(bus.cycle_count), 6);
        drive(1, 0, 0, 8'h00, 0);
        @(negedge clk); drive(0, 0, 0, 8'h00, 0); #1;
        chk("restart_wrap_clr", 32'(bus.wrap_err), 0);
        chk("restart_run", 32'(bus.fetch_valid), 1);
        drive(0, 0, 0, 8'h00, 1);
        @(negedge clk); drive(0, 0, 0, 8'h00, 0); #1;
        chk("halt_done", 32'(bus.done), 1);
        // saturation on a 4-bit counter
        bus4.start = 1;
        @(negedge clk); bus4.start = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk); #1;
            if (n == 14) chk("sat_count14", 32'(bus4.cycle_count), 14);
            if (n == 15) chk("sat_count15", 32'(bus4.cycle_count), 15);
        end
        chk("sat_count20", 32'(bus4.cycle_count), 15);
        chk("sat_busy", 32'(bus4.busy), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
